// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the pipelined multiplier.
//   MULT_LAT    : number of register stages between acceptance and result
//   mult_mode_t : per-operand signedness selection
//   limbs()     : number of LIMB_W-wide limbs in a w-bit operand
// ---------------------------------------------------------------------------
package mult_pkg;

    localparam int MULT_LAT = 4;

    typedef struct packed {
        logic a_sgn;
        logic b_sgn;
    } mult_mode_t;

    function automatic int limbs(input int w, input int lw);
        return w / lw;
    endfunction

endpackage

// File: rtl/mult_pp_array.sv
// ---------------------------------------------------------------------------
// mult_pp_array
// Second pipeline stage of mult_pipe: registers every LIMB_W x LIMB_W
// partial product of the two operand magnitudes.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset, clears all partial products
//   en     in   pipeline enable; registers hold when low
//   mag_a  in   A_W-bit unsigned magnitude of operand A
//   mag_b  in   B_W-bit unsigned magnitude of operand B
//   pp     out  packed partial products; pair (i,j) occupies slot i*NB+j,
//               each slot 2*LIMB_W bits wide
// ---------------------------------------------------------------------------
module mult_pp_array
    import mult_pkg::*;
#(
    parameter int A_W    = 32,
    parameter int B_W    = 32,
    parameter int LIMB_W = 16
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic                                                      en,
    input  logic [A_W-1:0]                                            mag_a,
    input  logic [B_W-1:0]                                            mag_b,
    output logic [limbs(A_W, LIMB_W)*limbs(B_W, LIMB_W)*2*LIMB_W-1:0] pp
);

    localparam int NA  = limbs(A_W, LIMB_W);
    localparam int NB  = limbs(B_W, LIMB_W);
    localparam int PPW = 2 * LIMB_W;

    // One small multiplier plus register per limb pair; each maps onto a
    // single DSP block in the target fabric.
    for (genvar i = 0; i < NA; i++) begin : g_a
        for (genvar j = 0; j < NB; j++) begin : g_b
            logic [PPW-1:0] pp_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pp_q <= '0;
                end else if (en) begin
                    pp_q <= PPW'(mag_a[i*LIMB_W +: LIMB_W]) * PPW'(mag_b[j*LIMB_W +: LIMB_W]);
                end
            end

            assign pp[(i*NB+j)*PPW +: PPW] = pp_q;
        end
    end

endmodule

// File: rtl/mult_pipe.sv
// ---------------------------------------------------------------------------
// mult_pipe
// Fully pipelined A_W x B_W integer multiplier supporting signed, unsigned
// and mixed-sign operands. Four stages, one operation per cycle, global
// stall on output backpressure.
//   S1: operand magnitudes and result sign
//   S2: limb partial products (mult_pp_array)
//   S3: shifted sum of partial products
//   S4: sign correction, result register
// Optional build macro MULT_TAG_EN adds in_tag/out_tag, a TAG_W-bit tag
// carried alongside each operation.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset, flushes the pipeline
//   in_valid   in   operation offered
//   in_ready   out  pipeline accepts an operation this cycle
//   in_a       in   operand A (A_W bits)
//   in_b       in   operand B (B_W bits)
//   in_a_sgn   in   1: A is two's complement, 0: unsigned
//   in_b_sgn   in   1: B is two's complement, 0: unsigned
//   out_valid  out  result available
//   out_ready  in   consumer accepts the result
//   out_p      out  full-width product (A_W+B_W bits)
//   in_tag     in   (MULT_TAG_EN only) operation tag
//   out_tag    out  (MULT_TAG_EN only) tag of the presented result
// ---------------------------------------------------------------------------
module mult_pipe
    import mult_pkg::*;
#(
    parameter int A_W    = 32,
    parameter int B_W    = 32,
    parameter int LIMB_W = 16,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       in_a,
    input  logic [B_W-1:0]       in_b,
    input  logic                 in_a_sgn,
    input  logic                 in_b_sgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   out_p
`ifdef MULT_TAG_EN
    ,
    input  logic [TAG_W-1:0]     in_tag,
    output logic [TAG_W-1:0]     out_tag
`endif
);

    localparam int P_W     = A_W + B_W;
    localparam int NA      = limbs(A_W, LIMB_W);
    localparam int NB      = limbs(B_W, LIMB_W);
    localparam int PPW     = 2 * LIMB_W;
    localparam int PP_BITS = NA * NB * PPW;

    if ((A_W % LIMB_W) != 0 || (B_W % LIMB_W) != 0) begin : g_bad_limb
        $error("mult_pipe: A_W and B_W must be multiples of LIMB_W");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("mult_pipe: TAG_W must be at least 1");
    end

    logic                en;
    logic [MULT_LAT-1:0] vld;
    mult_mode_t          mode;
    logic                neg_a;
    logic                neg_b;
    logic [A_W-1:0]      abs_a;
    logic [B_W-1:0]      abs_b;

    logic [A_W-1:0]      mag_a1;
    logic [B_W-1:0]      mag_b1;
    logic                neg1;
    logic                neg2;
    logic [PP_BITS-1:0]  pp2;
    logic [P_W-1:0]      sum;
    logic [P_W-1:0]      mag3;
    logic                neg3;
    logic [P_W-1:0]      p4;

    // The whole pipeline freezes only when a finished result is being
    // refused; a bubble in S4 or an accepting consumer keeps it moving.
    assign en        = !(out_valid && !out_ready);
    assign in_ready  = en;
    assign out_valid = vld[MULT_LAT-1];
    assign out_p     = p4;

    // Magnitude of the most-negative value still fits the unsigned width,
    // so the plain two's-complement negate is exact here.
    assign mode  = {in_a_sgn, in_b_sgn};
    assign neg_a = mode.a_sgn & in_a[A_W-1];
    assign neg_b = mode.b_sgn & in_b[B_W-1];
    assign abs_a = neg_a ? -in_a : in_a;
    assign abs_b = neg_b ? -in_b : in_b;

    // Valid bits shift with the data; a cleared bit is a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (en) begin
            vld <= {vld[MULT_LAT-2:0], in_valid};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_a1 <= '0;
            mag_b1 <= '0;
            neg1   <= 1'b0;
        end else if (en) begin
            mag_a1 <= abs_a;
            mag_b1 <= abs_b;
            neg1   <= neg_a ^ neg_b;
        end
    end

    mult_pp_array #(
        .A_W    (A_W),
        .B_W    (B_W),
        .LIMB_W (LIMB_W)
    ) u_pp_array (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mag_a (mag_a1),
        .mag_b (mag_b1),
        .pp    (pp2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg2 <= 1'b0;
        end else if (en) begin
            neg2 <= neg1;
        end
    end

    // Each partial product sits at the sum of its two limb offsets; the
    // total of unsigned magnitudes cannot exceed P_W bits.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NA; i++) begin
            for (int j = 0; j < NB; j++) begin
                sum = sum + (P_W'(pp2[(i*NB+j)*PPW +: PPW]) << ((i + j) * LIMB_W));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag3 <= '0;
            neg3 <= 1'b0;
        end else if (en) begin
            mag3 <= sum;
            neg3 <= neg2;
        end
    end

    // Negating a zero magnitude yields zero, so no special case is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p4 <= '0;
        end else if (en) begin
            p4 <= neg3 ? -mag3 : mag3;
        end
    end

`ifdef MULT_TAG_EN
    logic [TAG_W-1:0] tag_q [MULT_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MULT_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else if (en) begin
            tag_q[0] <= in_tag;
            for (int k = 1; k < MULT_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign out_tag = tag_q[MULT_LAT-1];
`endif

endmodule

// File: tb/tb_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_mult_pipe
// Scoreboard bench for mult_pipe with default parameters (32x32, 16-bit
// limbs). Directed vectors carry hand-computed products; a driver pushes the
// expected result when an operation is accepted and an independent monitor
// pops and compares on every output handshake.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mult_pipe;

    localparam int EXP_LAT = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        as;
        logic        bs;
        logic [63:0] p;
    } vec_t;

    typedef struct {
        logic [63:0] p;
        int          acc;
        logic [3:0]  tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_a_sgn;
    logic        in_b_sgn;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_p;
`ifdef MULT_TAG_EN
    logic [3:0]  in_tag;
    logic [3:0]  out_tag;
`endif

    exp_t        sb[$];
    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    bit          check_lat = 1'b1;
    logic [3:0]  tag_next  = 4'd0;
    bit          hold_pending = 1'b0;
    logic [63:0] held_p;

    vec_t t4 [8] = '{
        '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 64'h0000_0000_0000_000F},
        '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0000},
        '{32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 64'h0000_0001_0000_0000},
        '{32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA},
        '{32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, 64'h0000_0000_FFFE_0001},
        '{32'h1234_5678, 32'h0000_0010, 1'b0, 1'b0, 64'h0000_0001_2345_6780},
        '{32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000},
        '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 64'h3FFF_FFFF_0000_0001}
    };

    vec_t t5 [6] = '{
        '{32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 64'h0000_0000_0000_0006},
        '{32'h0000_0004, 32'h0000_0005, 1'b0, 1'b0, 64'h0000_0000_0000_0014},
        '{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB},
        '{32'h0000_0064, 32'h0000_0064, 1'b0, 1'b0, 64'h0000_0000_0000_2710},
        '{32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 64'h0000_0001_FFFF_FFFE},
        '{32'hFFFF_FFFB, 32'hFFFF_FFFB, 1'b1, 1'b1, 64'h0000_0000_0000_0019}
    };

    mult_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_a_sgn  (in_a_sgn),
        .in_b_sgn  (in_b_sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
`ifdef MULT_TAG_EN
        ,
        .in_tag    (in_tag),
        .out_tag   (out_tag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic failBound(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s bound expired", name);
    endtask

    // Offers one operation and holds it until accepted; the expected
    // product is queued at the moment of acceptance.
    task automatic applyStimulus(input vec_t v);
        int   waited = 0;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_a_sgn = v.as;
        in_b_sgn = v.bs;
`ifdef MULT_TAG_EN
        in_tag   = tag_next;
`endif
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            failBound("accept_wait");
            in_valid = 1'b0;
            return;
        end
        e.p   = v.p;
        e.acc = cyc;
        e.tag = tag_next;
        sb.push_back(e);
        tag_next = tag_next + 4'd1;
        @(posedge clk);
    endtask

    task automatic idleInput();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) failBound("drain");
        repeat (3) @(negedge clk);
    endtask

    // Holds out_ready low for three cycles once a result is showing.
    task automatic stallOutput();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            failBound("stall_wait");
            return;
        end
        out_ready = 1'b0;
        #1;
        checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
            checkOutput("stall_out_valid", {63'd0, out_valid}, 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
    endtask

    // Monitor: compares every output handshake against the scoreboard and
    // checks that a refused result does not change.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                hold_pending = 1'b0;
            end else if (out_valid) begin
                if (hold_pending) checkOutput("hold_stable", out_p, held_p);
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_output actual=0x%0h expected=none", out_p);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("product", out_p, e.p);
                        if (check_lat) checkOutput("latency", 64'(cyc - e.acc), 64'(EXP_LAT));
`ifdef MULT_TAG_EN
                        checkOutput("tag", {60'd0, out_tag}, {60'd0, e.tag});
`endif
                    end
                end
                hold_pending = !out_ready;
                held_p       = out_p;
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_a_sgn  = 1'b0;
        in_b_sgn  = 1'b0;
        out_ready = 1'b1;
`ifdef MULT_TAG_EN
        in_tag    = '0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("reset_out_p", out_p, 64'd0);
`ifdef MULT_TAG_EN
        checkOutput("reset_out_tag", {60'd0, out_tag}, 64'd0);
`endif
        rst = 1'b0;

        $display("[TB] directed signed/unsigned/mixed vectors");
        applyStimulus('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001});
        idleInput();
        drain();
        applyStimulus('{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000});
        applyStimulus('{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000});
        applyStimulus('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001});
        applyStimulus('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001});
        idleInput();
        drain();

        $display("[TB] back-to-back stream");
        tag_next = 4'd0;
        for (int i = 0; i < 8; i++) applyStimulus(t4[i]);
        idleInput();
        drain();

        $display("[TB] stream with output stall");
        check_lat = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) applyStimulus(t5[i]);
                idleInput();
            end
            stallOutput();
        join
        drain();
        check_lat = 1'b1;

        $display("[TB] reset with operations in flight");
        for (int i = 0; i < 3; i++) applyStimulus(t4[i]);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checkOutput("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midreset_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("midreset_out_p", out_p, 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus('{32'h0000_0007, 32'h0000_0006, 1'b0, 1'b0, 64'h0000_0000_0000_002A});
        idleInput();
        drain();
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
